// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if
// Issue bus between the instruction decoder and the execution sequencer.
// The decoder presents one decoded instruction with in_valid and the
// sequencer takes it in a cycle where in_ready is also high.
//   in_valid   decoder -> sequencer  instruction present
//   in_ready   sequencer -> decoder  sequencer can accept this cycle
//   ALUSelect  decoder -> sequencer  unit select (11 CORDIC, 10 FALU, 01 IALU, 00 none)
//   ALUOp      decoder -> sequencer  operation code
//   RWE        decoder -> sequencer  register write enable
//   load       decoder -> sequencer  load instruction
//   MWE        decoder -> sequencer  store instruction
//   rd         decoder -> sequencer  destination register
interface exec_sequencer_if #(
  parameter int ALUOP_WIDTH     = 5,
  parameter int ALUSELECT_WIDTH = 2,
  parameter int REG_ADDR_WIDTH  = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ALUSELECT_WIDTH-1:0] ALUSelect;
  logic [ALUOP_WIDTH-1:0]     ALUOp;
  logic                       RWE;
  logic                       load;
  logic                       MWE;
  logic [REG_ADDR_WIDTH-1:0]  rd;

  // Decoder side drives the instruction and watches in_ready
  modport master (
    output in_valid, ALUSelect, ALUOp, RWE, load, MWE, rd,
    input  in_ready
  );

  // Sequencer side consumes the instruction and drives in_ready
  modport slave (
    input  in_valid, ALUSelect, ALUOp, RWE, load, MWE, rd,
    output in_ready
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Issue/sequencing controller between the decoder and the execution units.
// Takes one decoded instruction at a time, dispatches it to IALU, FALU,
// CORDIC or LSU, stalls the decoder until the unit completes, then issues a
// one-cycle register-file writeback. A watchdog aborts multi-cycle
// operations that never report done.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   dec                   issue bus (slave side of exec_sequencer_if)
//   ialu_op               latched op for the single-cycle IALU
//   falu_start/falu_op    FALU start pulse and latched op
//   falu_done             FALU result valid
//   cordic_start          CORDIC start pulse
//   cordic_done           CORDIC result valid
//   mem_req/mem_we        LSU request pulse and write flag
//   mem_done              LSU access complete
//   wb_en/wb_addr/wb_src  register-file writeback strobe, address, source mux
//   busy                  an instruction is in flight
//   timeout_err           last operation was aborted by the watchdog
module exec_sequencer #(
  parameter int ALUOP_WIDTH     = 5,
  parameter int ALUSELECT_WIDTH = 2,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  exec_sequencer_if.slave           dec,
  output logic [ALUOP_WIDTH-1:0]    ialu_op,
  output logic                      falu_start,
  output logic [ALUOP_WIDTH-1:0]    falu_op,
  input  logic                      falu_done,
  output logic                      cordic_start,
  input  logic                      cordic_done,
  output logic                      mem_req,
  output logic                      mem_we,
  input  logic                      mem_done,
  output logic                      wb_en,
  output logic [REG_ADDR_WIDTH:0]   wb_addr,
  output logic [1:0]                wb_src,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC_I,
    WAIT_F,
    WAIT_C,
    WAIT_M,
    WB
  } state_t;

  // One spare bit so the terminal count always fits
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SRC_IALU   = 2'b00;
  localparam logic [1:0] SRC_FALU   = 2'b01;
  localparam logic [1:0] SRC_CORDIC = 2'b10;
  localparam logic [1:0] SRC_LSU    = 2'b11;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ALUOP_WIDTH-1:0]    op_q, op_d;
  logic                      rwe_q, rwe_d;
  logic                      store_q, store_d;
  logic                      falu_start_q, falu_start_d;
  logic                      cordic_start_q, cordic_start_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH:0]   wb_addr_q, wb_addr_d;
  logic [1:0]                wb_src_q, wb_src_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      own_done;

  // Next-state and next-output logic. Everything the later states need is
  // captured at accept time, so the WAIT/WB states only look at the done
  // input that belongs to the unit they are waiting on. A store never
  // writes back, and a done in the last allowed wait cycle beats the
  // watchdog because it is tested first.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    rwe_d          = rwe_q;
    store_d        = store_q;
    falu_start_d   = 1'b0;
    cordic_start_d = 1'b0;
    mem_req_d      = 1'b0;
    mem_we_d       = mem_we_q;
    wb_addr_d      = wb_addr_q;
    wb_src_d       = wb_src_q;
    timeout_err_d  = timeout_err_q;
    own_done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (dec.in_valid) begin
          op_d          = dec.ALUOp;
          rwe_d         = dec.RWE;
          store_d       = dec.MWE;
          mem_we_d      = dec.MWE;
          wb_addr_d     = {dec.ALUSelect[ALUSELECT_WIDTH-1], dec.rd};
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          if (dec.MWE || dec.load) begin
            state_d   = WAIT_M;
            mem_req_d = 1'b1;
            wb_src_d  = SRC_LSU;
          end else if (dec.ALUSelect == 2'b10) begin
            state_d      = WAIT_F;
            falu_start_d = 1'b1;
            wb_src_d     = SRC_FALU;
          end else if (dec.ALUSelect == 2'b11) begin
            state_d        = WAIT_C;
            cordic_start_d = 1'b1;
            wb_src_d       = SRC_CORDIC;
          end else begin
            state_d  = EXEC_I;
            wb_src_d = SRC_IALU;
          end
        end
      end
      EXEC_I: begin
        state_d = rwe_q ? WB : IDLE;
      end
      WAIT_F, WAIT_C, WAIT_M: begin
        if (state_q == WAIT_F) begin
          own_done = falu_done;
        end else if (state_q == WAIT_C) begin
          own_done = cordic_done;
        end else begin
          own_done = mem_done;
        end
        if (own_done) begin
          state_d = (rwe_q && !store_q) ? WB : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The writeback strobe is registered so it lines up with the WB state
  always_comb begin
    wb_en_d = (state_d == WB);
  end

  // State and output registers; reset abandons any in-flight operation
  // without a writeback and clears every registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      rwe_q          <= 1'b0;
      store_q        <= 1'b0;
      falu_start_q   <= 1'b0;
      cordic_start_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      wb_en_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_src_q       <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      rwe_q          <= rwe_d;
      store_q        <= store_d;
      falu_start_q   <= falu_start_d;
      cordic_start_q <= cordic_start_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      wb_en_q        <= wb_en_d;
      wb_addr_q      <= wb_addr_d;
      wb_src_q       <= wb_src_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // in_ready drops during reset even though the state is already IDLE
  always_comb begin
    dec.in_ready = (state_q == IDLE) && !reset;
    busy         = (state_q != IDLE);
    ialu_op      = op_q;
    falu_op      = op_q;
    falu_start   = falu_start_q;
    cordic_start = cordic_start_q;
    mem_req      = mem_req_q;
    mem_we       = mem_we_q;
    wb_en        = wb_en_q;
    wb_addr      = wb_addr_q;
    wb_src       = wb_src_q;
    timeout_err  = timeout_err_q;
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
// Directed bench for exec_sequencer with a short watchdog (8 cycles).
// Cycle k is the interval after clock edge k; an instruction is presented
// before edge 0, dones are driven during the cycle named in each record,
// and outputs are sampled on the falling edge of each cycle.
module tb_exec_sequencer;

  localparam int R_I = 0;
  localparam int R_F = 1;
  localparam int R_C = 2;
  localparam int R_M = 3;

  localparam int U_NONE = 0;
  localparam int U_F    = 1;
  localparam int U_C    = 2;
  localparam int U_M    = 3;

  typedef struct {
    logic [1:0] sel;
    logic [4:0] op;
    logic       rwe;
    logic       load;
    logic       mwe;
    logic [4:0] rd;
    int         route;
    int         doneUnit;
    int         doneCycle;
    bit         stray;
    bit         expWb;
    logic [5:0] expAddr;
    logic [1:0] expSrc;
    int         wbCycle;
    int         readyCycle;
    bit         expTmo;
    bit         expMemWe;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ialu_op;
  logic       falu_start;
  logic [4:0] falu_op;
  logic       falu_done;
  logic       cordic_start;
  logic       cordic_done;
  logic       mem_req;
  logic       mem_we;
  logic       mem_done;
  logic       wb_en;
  logic [5:0] wb_addr;
  logic [1:0] wb_src;
  logic       busy;
  logic       timeout_err;

  int checkCount = 0;
  int errorCount = 0;

  vec_t vecs[12];

  exec_sequencer_if #(
    .ALUOP_WIDTH(5), .ALUSELECT_WIDTH(2), .REG_ADDR_WIDTH(5)
  ) dec_if ();

  exec_sequencer #(
    .ALUOP_WIDTH(5),
    .ALUSELECT_WIDTH(2),
    .REG_ADDR_WIDTH(5),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dec(dec_if),
    .ialu_op(ialu_op),
    .falu_start(falu_start),
    .falu_op(falu_op),
    .falu_done(falu_done),
    .cordic_start(cordic_start),
    .cordic_done(cordic_done),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_done(mem_done),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_src(wb_src),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // One comparison; reports the cycle so a failure can be located
  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setDones(input logic f, input logic c, input logic m);
    falu_done   = f;
    cordic_done = c;
    mem_done    = m;
  endtask

  task automatic driveInstr(input logic [1:0] sel, input logic [4:0] op,
                            input logic rwe, input logic ld, input logic mwe,
                            input logic [4:0] rd);
    dec_if.in_valid  = 1'b1;
    dec_if.ALUSelect = sel;
    dec_if.ALUOp     = op;
    dec_if.RWE       = rwe;
    dec_if.load      = ld;
    dec_if.MWE       = mwe;
    dec_if.rd        = rd;
  endtask

  // Every registered output must be zero and nothing in flight
  task automatic checkCleared(input int cyc);
    checkOutput("clr.ialu_op", cyc, 32'(ialu_op), 0);
    checkOutput("clr.falu_op", cyc, 32'(falu_op), 0);
    checkOutput("clr.falu_start", cyc, 32'(falu_start), 0);
    checkOutput("clr.cordic_start", cyc, 32'(cordic_start), 0);
    checkOutput("clr.mem_req", cyc, 32'(mem_req), 0);
    checkOutput("clr.mem_we", cyc, 32'(mem_we), 0);
    checkOutput("clr.wb_en", cyc, 32'(wb_en), 0);
    checkOutput("clr.wb_addr", cyc, 32'(wb_addr), 0);
    checkOutput("clr.wb_src", cyc, 32'(wb_src), 0);
    checkOutput("clr.timeout_err", cyc, 32'(timeout_err), 0);
    checkOutput("clr.busy", cyc, 32'(busy), 0);
  endtask

  // Runs one instruction from accept to the cycle in_ready returns.
  // Entered and left on a falling edge with the sequencer idle.
  task automatic applyStimulus(input int idx, input vec_t v);
    bit  fd, cd, md;
    string tag;
    driveInstr(v.sel, v.op, v.rwe, v.load, v.mwe, v.rd);
    nextCycle();
    dec_if.in_valid = 1'b0;
    for (int cyc = 1; cyc <= v.readyCycle; cyc++) begin
      tag = $sformatf("v%0d", idx);
      fd = (cyc < v.readyCycle) &&
           ((v.doneUnit == U_F && cyc == v.doneCycle) || (v.stray && v.route != R_F));
      cd = (cyc < v.readyCycle) &&
           ((v.doneUnit == U_C && cyc == v.doneCycle) || (v.stray && v.route != R_C));
      md = (cyc < v.readyCycle) &&
           ((v.doneUnit == U_M && cyc == v.doneCycle) || (v.stray && v.route != R_M));
      setDones(fd, cd, md);
      @(negedge clk);
      checkOutput({tag, ".in_ready"}, cyc, 32'(dec_if.in_ready), 32'(cyc >= v.readyCycle));
      checkOutput({tag, ".busy"}, cyc, 32'(busy), 32'(cyc < v.readyCycle));
      checkOutput({tag, ".falu_start"}, cyc, 32'(falu_start), 32'(v.route == R_F && cyc == 1));
      checkOutput({tag, ".cordic_start"}, cyc, 32'(cordic_start), 32'(v.route == R_C && cyc == 1));
      checkOutput({tag, ".mem_req"}, cyc, 32'(mem_req), 32'(v.route == R_M && cyc == 1));
      checkOutput({tag, ".wb_en"}, cyc, 32'(wb_en), 32'(v.expWb && cyc == v.wbCycle));
      checkOutput({tag, ".timeout_err"}, cyc, 32'(timeout_err),
                  32'((cyc >= v.readyCycle) ? v.expTmo : 1'b0));
      if (v.expWb && cyc == v.wbCycle) begin
        checkOutput({tag, ".wb_addr"}, cyc, 32'(wb_addr), 32'(v.expAddr));
        checkOutput({tag, ".wb_src"}, cyc, 32'(wb_src), 32'(v.expSrc));
      end
      if (cyc == 1) begin
        checkOutput({tag, ".ialu_op"}, cyc, 32'(ialu_op), 32'(v.op));
        checkOutput({tag, ".falu_op"}, cyc, 32'(falu_op), 32'(v.op));
        checkOutput({tag, ".mem_we"}, cyc, 32'(mem_we), 32'(v.expMemWe));
      end
      if (cyc < v.readyCycle) begin
        nextCycle();
      end
    end
  endtask

  initial begin
    // sel, op, rwe, load, mwe, rd, route, doneUnit, doneCycle, stray,
    // expWb, expAddr, expSrc, wbCycle, readyCycle, expTmo, expMemWe
    vecs[0]  = '{2'b01, 5'd4,  1'b1, 1'b0, 1'b0, 5'd5,  R_I, U_NONE, 0, 1'b1,
                 1'b1, 6'h05, 2'b00, 2, 3,  1'b0, 1'b0};
    vecs[1]  = '{2'b01, 5'd9,  1'b0, 1'b0, 1'b0, 5'd2,  R_I, U_NONE, 0, 1'b0,
                 1'b0, 6'h00, 2'b00, 0, 2,  1'b0, 1'b0};
    vecs[2]  = '{2'b10, 5'd3,  1'b1, 1'b0, 1'b0, 5'd7,  R_F, U_F,    5, 1'b0,
                 1'b1, 6'h27, 2'b01, 6, 7,  1'b0, 1'b0};
    vecs[3]  = '{2'b11, 5'd6,  1'b1, 1'b0, 1'b0, 5'd1,  R_C, U_C,    1, 1'b1,
                 1'b1, 6'h21, 2'b10, 2, 3,  1'b0, 1'b0};
    vecs[4]  = '{2'b00, 5'd0,  1'b1, 1'b1, 1'b0, 5'd3,  R_M, U_M,    3, 1'b0,
                 1'b1, 6'h03, 2'b11, 4, 5,  1'b0, 1'b0};
    vecs[5]  = '{2'b00, 5'd0,  1'b0, 1'b0, 1'b1, 5'd4,  R_M, U_M,    2, 1'b0,
                 1'b0, 6'h00, 2'b00, 0, 3,  1'b0, 1'b1};
    vecs[6]  = '{2'b11, 5'd2,  1'b1, 1'b0, 1'b0, 5'd9,  R_C, U_NONE, 0, 1'b1,
                 1'b0, 6'h00, 2'b00, 0, 9,  1'b1, 1'b0};
    vecs[7]  = '{2'b11, 5'd8,  1'b1, 1'b0, 1'b0, 5'd10, R_C, U_C,    8, 1'b0,
                 1'b1, 6'h2A, 2'b10, 9, 10, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 5'd1,  1'b1, 1'b1, 1'b1, 5'd6,  R_M, U_M,    1, 1'b1,
                 1'b0, 6'h00, 2'b00, 0, 2,  1'b0, 1'b1};
    vecs[9]  = '{2'b10, 5'd12, 1'b0, 1'b0, 1'b0, 5'd8,  R_F, U_F,    2, 1'b0,
                 1'b0, 6'h00, 2'b00, 0, 3,  1'b0, 1'b0};
    vecs[10] = '{2'b00, 5'd31, 1'b1, 1'b0, 1'b0, 5'd31, R_I, U_NONE, 0, 1'b0,
                 1'b1, 6'h1F, 2'b00, 2, 3,  1'b0, 1'b0};
    vecs[11] = '{2'b11, 5'd0,  1'b0, 1'b1, 1'b0, 5'd11, R_M, U_M,    1, 1'b0,
                 1'b0, 6'h00, 2'b00, 0, 2,  1'b0, 1'b0};

    reset = 1'b1;
    dec_if.in_valid  = 1'b0;
    dec_if.ALUSelect = '0;
    dec_if.ALUOp     = '0;
    dec_if.RWE       = 1'b0;
    dec_if.load      = 1'b0;
    dec_if.MWE       = 1'b0;
    dec_if.rd        = '0;
    setDones(1'b0, 1'b0, 1'b0);

    // Reset state, and in_ready held low while reset is asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCleared(0);
    checkOutput("reset.in_ready", 0, 32'(dec_if.in_ready), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Second instruction held valid while the FALU op is busy: it must not
    // be taken until cycle 7, and must not disturb the first writeback.
    driveInstr(2'b10, 5'd3, 1'b1, 1'b0, 1'b0, 5'd7);
    nextCycle();
    driveInstr(2'b01, 5'd1, 1'b1, 1'b0, 1'b0, 5'd2);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      falu_done = (cyc == 5);
      @(negedge clk);
      checkOutput("hold.in_ready", cyc, 32'(dec_if.in_ready), 32'(cyc == 7 || cyc == 10));
      checkOutput("hold.wb_en", cyc, 32'(wb_en), 32'(cyc == 6 || cyc == 9));
      if (cyc <= 7) begin
        checkOutput("hold.ialu_op", cyc, 32'(ialu_op), 3);
      end else begin
        checkOutput("hold.ialu_op", cyc, 32'(ialu_op), 1);
      end
      if (cyc == 6) begin
        checkOutput("hold.wb_addr", cyc, 32'(wb_addr), 32'h27);
        checkOutput("hold.wb_src", cyc, 32'(wb_src), 1);
      end
      if (cyc == 9) begin
        checkOutput("hold.wb_addr", cyc, 32'(wb_addr), 32'h02);
        checkOutput("hold.wb_src", cyc, 32'(wb_src), 0);
      end
      if (cyc == 8) begin
        checkOutput("hold.busy", cyc, 32'(busy), 1);
      end
      if (cyc < 10) begin
        nextCycle();
        if (cyc == 7) begin
          dec_if.in_valid = 1'b0;
        end
      end
    end

    // Reset during cycle 3 of a FALU wait; the late done must be ignored
    driveInstr(2'b10, 5'd5, 1'b1, 1'b0, 1'b0, 5'd3);
    nextCycle();
    dec_if.in_valid = 1'b0;
    setDones(1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst.in_ready", 3, 32'(dec_if.in_ready), 0);
    checkOutput("rst.busy_before", 3, 32'(busy), 1);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkCleared(4);
    for (int cyc = 5; cyc <= 7; cyc++) begin
      nextCycle();
      falu_done = (cyc == 5);
      @(negedge clk);
      checkOutput("rst.wb_en", cyc, 32'(wb_en), 0);
      checkOutput("rst.busy", cyc, 32'(busy), 0);
      checkOutput("rst.in_ready", cyc, 32'(dec_if.in_ready), 1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
